// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// It sits on the core's data-memory port. Register decode and read data are
// combinational, so a load completes in the same cycle.
// Optional feature macro: UART_TX_IRQ_EN adds the irq output and the
// IRQCTRL register at offset 0xC. Without it, 0xC is reserved.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | line high, waiting for the FIFO to hold a byte
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | 8 data bits LSB-first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high); then chain straight into the next byte or go idle
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic [31:0] rdata,
  output logic        hit,
`ifdef UART_TX_IRQ_EN
  output logic        irq,
`endif
  output logic        tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;

  localparam logic [PW-1:0] PTR_ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_P     = PW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE    = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];

  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          busy;
  logic          we_txdata;
  logic          we_status;
  logic          push_ok;
  logic          pop;

  // Address/data bits the register window never looks at.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // Register window decode; mem_write only qualifies the write strobes.
  assign hit       = (addr[31:4] == BASE_ADDR[31:4]);
  assign we_txdata = hit & mem_write & (addr[3:2] == 2'd0);
  assign we_status = hit & mem_write & (addr[3:2] == 2'd1);

  // The extra pointer MSB distinguishes full from empty; full is judged
  // before the edge, so a same-edge pop never rescues a push into a full FIFO.
  assign count   = wptr_q - rptr_q;
  assign full    = (count == DEPTH_P);
  assign empty   = (wptr_q == rptr_q);
  assign busy    = (state_q != IDLE);
  assign push_ok = we_txdata & ~full;
  assign tx      = tx_q;

  // FIFO storage and pointer/overflow next-state.
  always_comb begin
    fifo_d = fifo_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    if (push_ok) begin
      fifo_d[wptr_q[AW-1:0]] = wdata[7:0];
      wptr_d = wptr_q + PTR_ONE;
    end
    if (pop) begin
      rptr_d = rptr_q + PTR_ONE;
    end
    if (we_status && wdata[3]) begin
      ovf_d = 1'b0;
    end
    if (we_txdata && full) begin
      ovf_d = 1'b1;
    end
  end

  // Serialiser FSM: baud down-counter reloads at every bit boundary.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rptr_q[AW-1:0]];
          baud_d  = BAUD_RELOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rptr_q[AW-1:0]];
            baud_d  = BAUD_RELOAD;
            state_d = START;
          end else begin
            baud_d  = '0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
    // tx is registered from the next state so the line changes with the state.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO storage has no reset; pointer reset alone discards its contents.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  // Control state with asynchronous reset; reset forces the line idle at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en_q, irq_en_d;
  logic irq_pend_q, irq_pend_d;
  logic irq_q, irq_d;
  logic we_irqctrl;
  logic enter_idle;

  assign we_irqctrl = hit & mem_write & (addr[3:2] == 2'd3);
  assign enter_idle = (state_q == STOP) && (state_d == IDLE);
  assign irq        = irq_q;

  // Interrupt control: a clear request beats a same-edge completion event.
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (enter_idle) begin
      irq_pend_d = 1'b1;
    end
    if (we_irqctrl) begin
      irq_en_d = wdata[0];
      if (wdata[1]) begin
        irq_pend_d = 1'b0;
      end
    end
    irq_d = irq_en_q & irq_pend_q;
  end

  // Interrupt registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end
`endif

  // Combinational read mux; zero whenever the window is not selected.
  always_comb begin
    rdata = '0;
    if (hit) begin
      case (addr[3:2])
        2'd1: begin
          rdata[14:8] = 7'(count);
          rdata[3]    = ovf_q;
          rdata[2]    = busy;
          rdata[1]    = empty;
          rdata[0]    = full;
        end
`ifdef UART_TX_IRQ_EN
        2'd3: begin
          rdata[1] = irq_pend_q;
          rdata[0] = irq_en_q;
        end
`endif
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Testbench for mmio_uart_tx: register table checks plus directed
// multi-cycle sequences for framing, chaining, overflow, reset abort and irq.
module tb_mmio_uart_tx;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 8;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  mmio_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .mem_write(mem_write),
    .rdata    (rdata),
    .hit      (hit),
`ifdef UART_TX_IRQ_EN
    .irq      (irq),
`endif
    .tx       (tx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected line level k cycles into a run of back-to-back frames.
  function automatic logic stream_bit(input int k);
    int f;
    int b;
    f = k / FRAME;
    b = (k % FRAME) / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return exp_bytes[f][b-1];
  endfunction

  // Called at a negedge; the write lands on the following posedge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
  endtask

  initial begin
    logic found;
    int   bad;

    vecs[0]  = '{BASE + 32'h4,  32'h0,        1'b0, 32'h0000_0002, 1'b1};
    vecs[1]  = '{32'h0000_0100, 32'h0,        1'b0, 32'h0,         1'b0};
    vecs[2]  = '{BASE + 32'h0,  32'h0,        1'b0, 32'h0,         1'b1};
    vecs[3]  = '{BASE + 32'h8,  32'h0,        1'b0, 32'h0,         1'b1};
    vecs[4]  = '{BASE + 32'hC,  32'h0,        1'b0, 32'h0,         1'b1};
    vecs[5]  = '{BASE + 32'h10, 32'h0,        1'b0, 32'h0,         1'b0};
    vecs[6]  = '{32'h0FFF_FFFC, 32'h0,        1'b0, 32'h0,         1'b0};
    vecs[7]  = '{32'h9000_0004, 32'h0,        1'b0, 32'h0,         1'b0};
    vecs[8]  = '{32'h0000_0100, 32'h5A,       1'b1, 32'h0,         1'b0};
    vecs[9]  = '{BASE + 32'h8,  32'hFF,       1'b1, 32'h0,         1'b1};
    vecs[10] = '{BASE + 32'h4,  32'h0,        1'b0, 32'h0000_0002, 1'b1};
    vecs[11] = '{BASE + 32'h4,  32'hFFFF_FFFF,1'b1, 32'h0000_0002, 1'b1};
    vecs[12] = '{BASE + 32'h4,  32'h0,        1'b0, 32'h0000_0002, 1'b1};

    reset     = 1'b1;
    addr      = '0;
    wdata     = '0;
    mem_write = 1'b0;
    repeat (2) @(negedge clk);
    check("tx_in_reset", 32'(tx), 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // Register window table: decode, reserved registers, ignored writes.
    for (int i = 0; i < NV; i++) begin
      addr      = vecs[i].addr;
      wdata     = vecs[i].wdata;
      mem_write = vecs[i].we;
      #1;
      check($sformatf("vec%0d_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      @(negedge clk);
    end
    mem_write = 1'b0;
    check("tx_idle_after_table", 32'(tx), 32'h1);

    // Single frame 0xA5: one-edge latency, exact bit timing, busy throughout.
    exp_bytes[0] = 8'hA5;
    wr(BASE, 32'hA5);
    addr = BASE + 32'h4;
    #1;
    check("a5_queued_status", rdata, 32'h0000_0100);
    check("a5_tx_before_start", 32'(tx), 32'h1);
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      check($sformatf("a5_tx_k%0d", k), 32'(tx), 32'(stream_bit(k)));
      check($sformatf("a5_busy_k%0d", k), 32'(rdata[2]), 32'h1);
    end
    @(negedge clk);
    check("a5_tx_after", 32'(tx), 32'h1);
    check("a5_status_after", rdata, 32'h0000_0002);

    // Three back-to-back bytes: no idle gap, count 2,1,0 at frame starts.
    exp_bytes[0] = 8'h01;
    exp_bytes[1] = 8'hFE;
    exp_bytes[2] = 8'h5C;
    wr(BASE, 32'h01);
    wr(BASE, 32'hFE);
    wr(BASE, 32'h5C);
    addr = BASE + 32'h4;
    #1;
    check("b3_count_k1", 32'(rdata[14:8]), 32'd2);
    check("b3_tx_k1", 32'(tx), 32'(stream_bit(1)));
    for (int k = 2; k < 3 * FRAME; k++) begin
      @(negedge clk);
      check($sformatf("b3_tx_k%0d", k), 32'(tx), 32'(stream_bit(k)));
      check($sformatf("b3_busy_k%0d", k), 32'(rdata[2]), 32'h1);
      if (k == FRAME) check("b3_count_f2", 32'(rdata[14:8]), 32'd1);
      if (k == 2 * FRAME) check("b3_count_f3", 32'(rdata[14:8]), 32'd0);
    end
    @(negedge clk);
    check("b3_tx_after", 32'(tx), 32'h1);
    check("b3_status_after", rdata, 32'h0000_0002);

    // Overflow: line busy with a dummy frame, push 10 bytes into 8 slots.
    wr(BASE, 32'hFF);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      exp_bytes[i] = 8'(8'h11 * (i + 1));
      wr(BASE, {24'h0, exp_bytes[i]});
    end
    addr = BASE + 32'h4;
    #1;
    check("ovf_status_full", rdata, 32'h0000_080D);
    wr(BASE + 32'h4, 32'h8);
    #1;
    check("ovf_status_cleared", rdata, 32'h0000_0805);
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    check("ovf_first_start_seen", 32'(found), 32'h1);
    if (found) begin
      for (int k = 1; k < DEPTH * FRAME; k++) begin
        @(negedge clk);
        check($sformatf("ovf_tx_k%0d", k), 32'(tx), 32'(stream_bit(k)));
      end
      bad = 0;
      repeat (2 * FRAME) begin
        @(negedge clk);
        if (tx !== 1'b1) bad++;
      end
      check("ovf_no_ninth_frame", 32'(bad), 32'h0);
      check("ovf_status_end", rdata, 32'h0000_0002);
    end

    // Reset in the middle of a data bit with two more bytes queued.
    exp_bytes[0] = 8'h3C;
    wr(BASE, 32'h3C);
    wr(BASE, 32'h11);
    wr(BASE, 32'h22);
    repeat (10) @(negedge clk);
    check("rst_tx_before", 32'(tx), 32'(stream_bit(11)));
    reset = 1'b1;
    #1;
    check("rst_tx_async", 32'(tx), 32'h1);
    @(negedge clk);
    reset = 1'b0;
    addr  = BASE + 32'h4;
    #1;
    check("rst_status_after", rdata, 32'h0000_0002);
    bad = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("rst_no_frames", 32'(bad), 32'h0);
    check("rst_status_end", rdata, 32'h0000_0002);

`ifdef UART_TX_IRQ_EN
    // Interrupt on end of the last frame, cleared by writing the pending bit.
    wr(BASE + 32'hC, 32'h1);
    addr = BASE + 32'hC;
    #1;
    check("irq_enable_readback", rdata, 32'h1);
    check("irq_low_initial", 32'(irq), 32'h0);
    wr(BASE, 32'h81);
    addr = BASE + 32'hC;
    repeat (FRAME + 1) @(negedge clk);
    check("irq_pending_set", rdata, 32'h3);
    check("irq_low_at_stop_end", 32'(irq), 32'h0);
    @(negedge clk);
    check("irq_rise", 32'(irq), 32'h1);
    wr(BASE + 32'hC, 32'h2);
    addr = BASE + 32'hC;
    @(negedge clk);
    check("irq_fall", 32'(irq), 32'h0);
    check("irq_ctrl_cleared", rdata, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
